simon_core_param: RTL

// - Generic iterative SIMON block cipher. Supersedes the fixed 64/96 top.
// - Supports every SIMON word size N and key-word count M, and encryption or decryption.
// - Runs one round per clk and buffers the expanded key schedule, so a key is expanded

---
 rtl/simon_core_param_if.sv | 28 ++
 rtl/simon_core_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_core_param_if.sv
// Host-side handshake and data bus for simon_core_param. The host drives the master modport.
interface simon_core_param_if #(
  parameter int N = 32,
  parameter int M = 3
);
  logic                  newKey;
  logic [M-1:0][N-1:0]   KEY;
  logic                  newData;
  logic                  enc_dec;
  logic [1:0][N-1:0]     BLOCK;
  logic                  readData;
  logic                  loadKey;
  logic                  loadData;
  logic                  doneKey;
  logic                  doneData;
  logic [1:0][N-1:0]     outData;
  logic [3:0]            mode;

  modport master (
    output newKey, KEY, newData, enc_dec, BLOCK, readData,
    input  loadKey, loadData, doneKey, doneData, outData, mode
  );

  modport slave (
    input  newKey, KEY, newData, enc_dec, BLOCK, readData,
    output loadKey, loadData, doneKey, doneData, outData, mode
  );
endinterface

// File: rtl/simon_core_param.sv
// Iterative SIMON (any legal N/M): expands the key once into a schedule RAM, then one round per clk.
// Optional feature macro SIMON_DECRYPT_EN adds the decrypt datapath and reverse key addressing.
module simon_core_param #(
  parameter int N  = 32,
  parameter int M  = 3,
  parameter int Cb = 7
) (
  input logic               clk,
  input logic               R,
  simon_core_param_if.slave bus
);
  function automatic int rounds_for(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24 && m == 3) return 36;
    if (n == 24 && m == 4) return 36;
    if (n == 32 && m == 3) return 42;
    if (n == 32 && m == 4) return 44;
    if (n == 48 && m == 2) return 52;
    if (n == 48 && m == 3) return 54;
    if (n == 64 && m == 2) return 68;
    if (n == 64 && m == 3) return 69;
    if (n == 64 && m == 4) return 72;
    return 0;
  endfunction

  // Sequences are written z[0] first, so bit j of the sequence sits at literal bit 61-j.
  function automatic logic [61:0] z_for(input int n, input int m);
    logic [61:0] z0, z1, z2, z3, z4;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    if (n == 16)            return z0;
    if (n == 24)            return (m == 3) ? z0 : z1;
    if (n == 32)            return (m == 3) ? z2 : z3;
    if (n == 48)            return (m == 2) ? z2 : z3;
    if (m == 2)             return z2;
    if (m == 3)             return z3;
    return z4;
  endfunction

  localparam int              T    = rounds_for(N, M);
  localparam int              TD   = (T > 0) ? T : 2;
  localparam int              AW   = $clog2(TD);
  localparam logic [61:0]     ZSEQ = z_for(N, M);
  localparam logic [Cb-1:0]   LAST = Cb'(TD - 1);

  if (T == 0) begin : g_bad_nm
    $error("simon_core_param: unsupported N=%0d M=%0d", N, M);
  end
  if ((1 << Cb) <= T) begin : g_bad_cb
    $error("simon_core_param: Cb=%0d too small for T=%0d", Cb, T);
  end

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] sf(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    KEXP  = 4'd1,
    READY = 4'd2,
    RUN   = 4'd3,
    DONE  = 4'd4
  } state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      kreg [M];
  logic [N-1:0]      win  [M];
  logic [N-1:0]      ram  [TD];
  logic [Cb-1:0]     kidx, rcnt, raddr;
  logic [5:0]        zi;
  logic [N-1:0]      x, y, rk, knew, ktmp;
  logic              kvalid, done_key_q, done_data_q, load_key, load_data, key_cap;
  logic [1:0][N-1:0] out_q;

  assign bus.loadKey  = load_key;
  assign bus.loadData = load_data;
  assign bus.doneKey  = done_key_q;
  assign bus.doneData = done_data_q;
  assign bus.outData  = out_q;
  assign bus.mode     = state;

  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_key  = 1'b0;
    load_data = 1'b0;
    case (state)
      IDLE: begin
        load_key = 1'b1;
        if (bus.newKey) state_nxt = KEXP;
      end
      KEXP:  if (kidx == LAST) state_nxt = READY;
      READY: begin
        load_key  = 1'b1;
        load_data = 1'b1;
        if (bus.newData && kvalid) state_nxt = RUN;
        else if (bus.newKey)       state_nxt = KEXP;
      end
      RUN:   if (rcnt == LAST) state_nxt = DONE;
      DONE:  if (done_data_q && bus.readData) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  assign key_cap = (state != KEXP) && (state_nxt == KEXP);

  // Only the last M words are needed to produce the next one, so expansion runs
  // from a shift window while the RAM only ever sees a single write per cycle.
  always_comb begin
    ktmp = ror(win[M-1], 3);
    if (M == 4) ktmp = ktmp ^ win[1];
    ktmp = ktmp ^ ror(ktmp, 1);
    knew = ~win[0] ^ ktmp ^ N'(ZSEQ[6'd61 - zi]) ^ N'(3);
  end

  always_ff @(posedge clk) begin
    if (key_cap) begin
      for (int unsigned j = 0; j < M; j++) begin
        kreg[j] <= bus.KEY[j];
        win[j]  <= bus.KEY[j];
      end
    end else if (state == KEXP) begin
      for (int unsigned j = 0; j + 1 < M; j++) win[j] <= win[j+1];
      win[M-1]             <= knew;
      ram[kidx[AW-1:0]]    <= knew;
    end
  end

`ifdef SIMON_DECRYPT_EN
  logic decr;
  assign raddr = decr ? (LAST - rcnt) : rcnt;
`else
  logic unused_enc_dec;
  assign unused_enc_dec = bus.enc_dec;
  assign raddr          = rcnt;
`endif

  // Words 0..M-1 live in the captured key registers; the RAM holds M..T-1.
  always_comb begin
    rk = ram[raddr[AW-1:0]];
    for (int unsigned j = 0; j < M; j++)
      if (raddr == Cb'(j)) rk = kreg[j];
  end

  always_ff @(posedge clk) begin
    if (R) begin
      kidx        <= '0;
      zi          <= '0;
      rcnt        <= '0;
      x           <= '0;
      y           <= '0;
      kvalid      <= 1'b0;
      done_key_q  <= 1'b0;
      done_data_q <= 1'b0;
      out_q       <= '0;
`ifdef SIMON_DECRYPT_EN
      decr        <= 1'b0;
`endif
    end else begin
      done_key_q <= 1'b0;
      if (key_cap) begin
        kidx   <= Cb'(M);
        zi     <= '0;
        kvalid <= 1'b0;
      end
      case (state)
        KEXP: begin
          kidx <= (kidx == LAST) ? kidx : kidx + Cb'(1);
          zi   <= (zi == 6'd61) ? '0 : zi + 6'd1;
          if (kidx == LAST) begin
            done_key_q <= 1'b1;
            kvalid     <= 1'b1;
          end
        end
        READY: if (bus.newData && kvalid) begin
          x    <= bus.BLOCK[1];
          y    <= bus.BLOCK[0];
          rcnt <= '0;
`ifdef SIMON_DECRYPT_EN
          decr <= ~bus.enc_dec;
`endif
        end
        RUN: begin
`ifdef SIMON_DECRYPT_EN
          if (decr) begin
            x <= y;
            y <= x ^ sf(y) ^ rk;
          end else
`endif
          begin
            x <= y ^ sf(x) ^ rk;
            y <= x;
          end
          if (rcnt != LAST) rcnt <= rcnt + Cb'(1);
        end
        DONE: begin
          if (!done_data_q) begin
            out_q       <= {x, y};
            done_data_q <= 1'b1;
          end else if (bus.readData) begin
            done_data_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
